// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: operand beat bus (in_valid/in_ready handshake carrying one A column and one B row)
interface systolic_skew_feeder_if #(
  parameter int SIZE = 8,
  parameter int DATA_WIDTH = 8
);
  logic in_valid;
  logic in_ready;
  logic [SIZE*DATA_WIDTH-1:0] a_col;
  logic [SIZE*DATA_WIDTH-1:0] b_row;
  modport master(output in_valid, a_col, b_row, input in_ready);
  modport slave(input in_valid, a_col, b_row, output in_ready);
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews A/B beats (bus) into a SIZE x SIZE systolic array and sequences arr_en/arr_clr/busy/done (clk, rst active-low async, start, k_len)
module systolic_skew_feeder #(
  parameter int SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_K = 16,
  parameter int PE_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_K):0]       k_len,
  systolic_skew_feeder_if.slave        bus,
  output logic [SIZE*DATA_WIDTH-1:0]   a_skew,
  output logic [SIZE*DATA_WIDTH-1:0]   b_skew,
  output logic                         arr_en,
  output logic                         arr_clr,
  output logic                         busy,
  output logic                         done
);
  localparam int DRAIN_CYC = 3*SIZE-3+PE_LATENCY;
  localparam int KW = $clog2(MAX_K)+1;
  localparam int CW = $clog2((DRAIN_CYC > MAX_K ? DRAIN_CYC : MAX_K) + 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, k_q, k_d;
  logic [KW-1:0] k_clamp;
  assign k_clamp = k_len > KW'(MAX_K) ? KW'(MAX_K) : k_len;
  assign bus.in_ready = state_q == LOAD;
  assign busy = state_q == LOAD || state_q == DRAIN;
  assign done = state_q == DONE;
  assign arr_en = (state_q == LOAD && bus.in_valid) || state_q == DRAIN;
  assign arr_clr = rst && state_q == IDLE && start;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (start) begin
        k_d = CW'(k_clamp);
        cnt_d = '0;
        state_d = k_clamp == '0 ? DONE : LOAD;
      end
      LOAD: if (bus.in_valid) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == k_q) begin
          state_d = DRAIN;
          cnt_d = CW'(DRAIN_CYC);
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
    end
  for (genvar g = 0; g < SIZE; g++) begin : lane
    logic [DATA_WIDTH-1:0] a_q [g+1];
    logic [DATA_WIDTH-1:0] a_d [g+1];
    logic [DATA_WIDTH-1:0] b_q [g+1];
    logic [DATA_WIDTH-1:0] b_d [g+1];
    always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (arr_en) begin
        a_d[0] = state_q == LOAD ? bus.a_col[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_d[0] = state_q == LOAD ? bus.b_row[g*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= g; s++) begin
          a_d[s] = a_q[s-1];
          b_d[s] = b_q[s-1];
        end
      end
    end
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        a_q <= '{default: '0};
        b_q <= '{default: '0};
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    assign a_skew[g*DATA_WIDTH +: DATA_WIDTH] = a_q[g];
    assign b_skew[g*DATA_WIDTH +: DATA_WIDTH] = b_q[g];
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: randomized check of systolic_skew_feeder against a history/array reference model
module tb_systolic_skew_feeder;
  logic clk = 0, rst = 0, start = 0;
  logic [4:0] k_len = 0;
  logic [63:0] a_skew, b_skew;
  logic arr_en, arr_clr, busy, done;
  int checks = 0, failures = 0;
  systolic_skew_feeder_if #(.SIZE(8), .DATA_WIDTH(8)) bus();
  systolic_skew_feeder dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .bus(bus),
    .a_skew(a_skew), .b_skew(b_skew), .arr_en(arr_en), .arr_clr(arr_clr),
    .busy(busy), .done(done)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ln(input logic [63:0] v, input int i);
    return v[i*8 +: 8];
  endfunction
  logic [63:0] ha[$], hb[$];
  int unsigned gold [8][8], cm [8][8];
  logic [7:0] ar [8][8], br [8][8];
  bit loading = 0;
  int kk = 0, accepted = 0, done_at = -1, cyc = 0;
  always @(negedge clk) begin
    logic [63:0] ea, eb;
    logic [7:0] ain, bin;
    bit busy_e, idle_e, en_e, clr_e, done_e;
    int x;
    if (!rst) begin
      loading = 0;
      done_at = -1;
      ha.delete();
      hb.delete();
    end
    busy_e = loading || cyc < done_at;
    idle_e = !loading && cyc > done_at;
    en_e = (loading && bus.in_valid) || (busy_e && !loading);
    clr_e = rst && idle_e && start;
    done_e = rst && cyc == done_at;
    ea = '0;
    eb = '0;
    for (int i = 0; i < 8; i++) begin
      x = ha.size() - 1 - i;
      if (x >= 0) begin
        ea[i*8 +: 8] = ln(ha[x], i);
        eb[i*8 +: 8] = ln(hb[x], i);
      end
    end
    chk("in_ready", bus.in_ready, loading);
    chk("busy", busy, busy_e);
    chk("done", done, done_e);
    chk("arr_en", arr_en, en_e);
    chk("arr_clr", arr_clr, clr_e);
    chk("a_skew", a_skew, ea);
    chk("b_skew", b_skew, eb);
    if (done_e)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          chk($sformatf("c[%0d][%0d]", i, j), cm[i][j], gold[i][j]);
    if (rst) begin
      if (clr_e) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) begin
            cm[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
          end
      end else if (en_e) begin
        for (int i = 7; i >= 0; i--)
          for (int j = 7; j >= 0; j--) begin
            ain = j == 0 ? ln(a_skew, i) : ar[i][j-1];
            bin = i == 0 ? ln(b_skew, j) : br[i-1][j];
            cm[i][j] += 32'(ain) * 32'(bin);
            ar[i][j] = ain;
            br[i][j] = bin;
          end
      end
      if (en_e) begin
        ha.push_back(loading ? bus.a_col : 64'h0);
        hb.push_back(loading ? bus.b_row : 64'h0);
        if (ha.size() > 8) begin
          void'(ha.pop_front());
          void'(hb.pop_front());
        end
      end
      if (clr_e) begin
        kk = k_len > 16 ? 16 : int'(k_len);
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) gold[i][j] = 0;
        if (kk == 0) done_at = cyc + 1;
        else begin
          loading = 1;
          accepted = 0;
        end
      end else if (loading && bus.in_valid) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            gold[i][j] += 32'(ln(bus.a_col, i)) * 32'(ln(bus.b_row, j));
        accepted++;
        if (accepted == kk) begin
          loading = 0;
          done_at = cyc + 23;
        end
      end
      cyc++;
    end
  end
  task automatic run_job(input int k, input int bub, input int gap_at, input bit noise,
                         input logic [63:0] fa, input logic [63:0] fb, input bit fix,
                         output int done_t, output int lat);
    int acc = 0, gap = 0, last = -1;
    bit seen = 0;
    done_t = -1;
    lat = -1;
    @(posedge clk); #1;
    start = 1; k_len = 5'(k); bus.in_valid = 0;
    @(posedge clk); #1;
    start = 0;
    for (int t = 0; t < 400; t++) begin
      if (done) begin
        seen = 1;
        done_t = t;
        lat = t - last;
        break;
      end
      if (gap > 0) begin
        bus.in_valid = 0;
        gap--;
      end else bus.in_valid = $urandom_range(99) >= bub;
      bus.a_col = {$urandom, $urandom};
      bus.b_row = {$urandom, $urandom};
      if (fix && acc == 0) begin
        bus.a_col = fa;
        bus.b_row = fb;
      end
      start = noise && busy && $urandom_range(2) == 0;
      k_len = 5'($urandom);
      if (bus.in_valid && bus.in_ready) begin
        acc++;
        last = t;
        if (acc == gap_at) gap = 3;
      end
      @(posedge clk); #1;
    end
    if (!seen) chk("timeout", 0, 1);
    bus.in_valid = 0;
    start = noise && $urandom_range(1) == 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  initial begin
    int dt, lat, k;
    bus.in_valid = 0;
    bus.a_col = '0;
    bus.b_row = '0;
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_askew", a_skew, 0);
    chk("rst_done", done, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("idle_ready", bus.in_ready, 0);
    run_job(1, 0, 0, 0, 64'd37, 64'd2, 1, dt, lat);
    chk("single_lat", lat, 23);
    run_job(8, 0, 0, 1, {48'h0, 8'd45, 8'd60}, {48'h0, 8'd30, 8'd47}, 1, dt, lat);
    chk("full_lat", lat, 23);
    chk("full_total", dt, 30);
    run_job(4, 0, 2, 0, 0, 0, 0, dt, lat);
    chk("bubble_total", dt, 29);
    chk("bubble_lat", lat, 23);
    run_job(0, 0, 0, 0, 0, 0, 0, dt, lat);
    chk("k0_done", dt, 0);
    run_job(31, 0, 0, 1, 0, 0, 0, dt, lat);
    chk("clamp_total", dt, 38);
    @(posedge clk); #1;
    start = 1; k_len = 3;
    @(posedge clk); #1;
    start = 0;
    bus.in_valid = 1;
    repeat (3) begin
      bus.a_col = {$urandom, $urandom};
      bus.b_row = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_busy", busy, 1);
    chk("drain_askew_nz", a_skew != 0 || b_skew != 0 || arr_en, 1);
    #1 rst = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", arr_en, 0);
    chk("arst_a", a_skew, 0);
    chk("arst_b", b_skew, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (30) @(posedge clk);
    #1;
    run_job(5, 20, 0, 1, 0, 0, 0, dt, lat);
    chk("after_rst_lat", lat, 23);
    repeat (8) begin
      k = $urandom_range(0, 31);
      run_job(k, $urandom_range(0, 50), 0, 1, 0, 0, 0, dt, lat);
      if (k > 0) chk("rand_lat", lat, 23);
      else chk("rand_k0", dt, 0);
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
